lu_wrback: RTL and testbench
============================

LU_WRBACK -- requirements
Module: lu_wrback

Interface
REQ-001 Parameter BEATS_PER_BLK, default 16, NET_DWIDTH-wide beats per block packet (power of two, >=2).
REQ-002 Parameter ADDR_WIDTH, default 24, width of the memory beat address.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_bstride  input  MAX_BDIMBITS  blocks per matrix row; quasi-static while any packet is in flight.
REQ-006 i_wrreq_valid / o_wrreq_ready  input/output  1  write-stream handshake from the CPU block.
REQ-007 i_wrreq_data  input  NET_DWIDTH  beat payload.
REQ-008 i_wrreq_x, i_wrreq_y  input  MAX_BDIMBITS each  block coordinates, meaningful on the SOP beat only.
REQ-009 i_wrreq_sop, i_wrreq_eop  input  1 each  packet delimiters.
REQ-010 o_mem_valid / i_mem_ready  output/input  1  memory write handshake.
REQ-011 o_mem_addr  output  ADDR_WIDTH  beat address; o_mem_data  output  NET_DWIDTH  beat data.
REQ-012 o_blkdone_valid / i_blkdone_ready  output/input  1  block-written notification handshake.
REQ-013 o_blkdone_x, o_blkdone_y  output  MAX_BDIMBITS each  coordinates of the completed block.
REQ-014 o_err  output  1  sticky protocol-error flag (present only per REQ-031).

Function
REQ-015 A transfer occurs on any interface in a cycle where valid and ready are both 1; valid, once raised, holds with stable payload until accepted.
REQ-016 FSM states IDLE, STREAM, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE: o_wrreq_ready = output slot free-or-draining; a transfer with sop=1 latches x,y, clears beat counter, goes to STREAM (or DRAIN if eop=1 on the same beat).
REQ-018 IDLE: a transfer with sop=0 is consumed and discarded, no memory write.
REQ-019 STREAM: each transfer is written; beat counter increments; transfer with eop=1 moves to DRAIN; sop=1 in STREAM is ignored as a delimiter (beat written as data).
REQ-020 Address = (y*i_bstride + x)*BEATS_PER_BLK + beat, computed in ADDR_WIDTH bits, truncated modulo 2^ADDR_WIDTH.
REQ-021 Output slot is a single register: accepted beat at cycle N appears on o_mem_* at N+1; o_wrreq_ready = (!o_mem_valid || i_mem_ready) in IDLE/STREAM, 0 in DRAIN/DONE.
REQ-022 Full throughput: one beat per cycle sustained when i_mem_ready stays 1.
REQ-023 DRAIN: wait until output slot empties (last beat accepted by memory), then DONE.
REQ-024 DONE: o_blkdone_valid=1 with latched x,y; on i_blkdone_ready go to IDLE; the next packet's SOP is accepted no earlier than the cycle after.
REQ-025 Beat counter saturates at BEATS_PER_BLK-1; overlong packets keep rewriting the final address.

Reset
REQ-026 reset_n low asynchronously forces IDLE, beat counter 0, o_mem_valid=0, o_blkdone_valid=0, o_err=0, o_wrreq_ready=0.
REQ-027 Reset mid-packet discards the in-flight beat and packet; no done is issued; first cycle after release o_wrreq_ready may assert.
REQ-028 Data/address registers need not be reset.

Configuration
REQ-029 Macro LU_WRBACK_ERRCHK_EN enables protocol checking.
REQ-030 With it: o_err sets on headless beat (REQ-018), sop inside STREAM, eop at beat count != BEATS_PER_BLK-1, or beat beyond saturation; clears only on reset.
REQ-031 Without it: o_err port exists and is tied 0; datapath behaviour identical.

Structure
REQ-032 BEATS_PER_BLK default, t_wrback_state enum and address-width constant go in package lu_new alongside NET_DWIDTH and MAX_BDIMBITS.
REQ-033 One sub-module, lu_wrback_addrgen: registered base address (y*i_bstride + x)*BEATS_PER_BLK computed at SOP, plus beat offset.

Verification
REQ-034 16-beat packet x=2,y=3,bstride=4, mem_ready=1 -> addrs 224..239 at consecutive cycles, done(2,3) one cycle after last mem accept.
REQ-035 Same packet with mem_ready toggling 1/0 -> no beat lost/duplicated, o_wrreq_ready low whenever slot full and mem_ready=0.
REQ-036 Back-to-back packets, blkdone_ready held 0 for 5 cycles -> second SOP not accepted until cycle after done accepted.
REQ-037 Beat with sop=0 in IDLE then valid packet -> first beat dropped, o_err=1 (ERRCHK_EN) / 0 (disabled), packet written normally.
REQ-038 eop on beat 9 of 16 -> done issued after beat 9, o_err=1 with ERRCHK_EN.
REQ-039 reset_n low at beat 7 -> all valids 0 immediately; next full packet completes with correct addresses.

Source files
------------

// File: rtl/lu_wrback_pkg.sv
// Shared types and constants for the block write-back path.
package lu_new;

    localparam int NET_DWIDTH       = 32;
    localparam int MAX_BDIMBITS     = 8;
    localparam int LU_BEATS_PER_BLK = 16;
    localparam int LU_ADDR_WIDTH    = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } t_wrback_state;

endpackage

// File: rtl/lu_wrback_if.sv
// Write-stream, memory-write and block-done handshakes of lu_wrback.
interface lu_wrback_if #(
    parameter int ADDR_WIDTH = lu_new::LU_ADDR_WIDTH
);
    localparam int DW = lu_new::NET_DWIDTH;
    localparam int BW = lu_new::MAX_BDIMBITS;

    logic [BW-1:0]         i_bstride;
    logic                  i_wrreq_valid;
    logic                  o_wrreq_ready;
    logic [DW-1:0]         i_wrreq_data;
    logic [BW-1:0]         i_wrreq_x;
    logic [BW-1:0]         i_wrreq_y;
    logic                  i_wrreq_sop;
    logic                  i_wrreq_eop;
    logic                  o_mem_valid;
    logic                  i_mem_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DW-1:0]         o_mem_data;
    logic                  o_blkdone_valid;
    logic                  i_blkdone_ready;
    logic [BW-1:0]         o_blkdone_x;
    logic [BW-1:0]         o_blkdone_y;
    logic                  o_err;

    modport slave (
        input  i_bstride, i_wrreq_valid, i_wrreq_data,
        input  i_wrreq_x, i_wrreq_y, i_wrreq_sop, i_wrreq_eop,
        input  i_mem_ready, i_blkdone_ready,
        output o_wrreq_ready, o_mem_valid, o_mem_addr, o_mem_data,
        output o_blkdone_valid, o_blkdone_x, o_blkdone_y, o_err
    );

    modport master (
        output i_bstride, i_wrreq_valid, i_wrreq_data,
        output i_wrreq_x, i_wrreq_y, i_wrreq_sop, i_wrreq_eop,
        output i_mem_ready, i_blkdone_ready,
        input  o_wrreq_ready, o_mem_valid, o_mem_addr, o_mem_data,
        input  o_blkdone_valid, o_blkdone_x, o_blkdone_y, o_err
    );

endinterface

// File: rtl/lu_wrback_addrgen.sv
// Block base address, captured on the SOP beat, plus beat offset.
module lu_wrback_addrgen
    import lu_new::*;
#(
    parameter int BEATS_PER_BLK = LU_BEATS_PER_BLK,
    parameter int ADDR_WIDTH    = LU_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             load,
    input  logic [MAX_BDIMBITS-1:0]          x,
    input  logic [MAX_BDIMBITS-1:0]          y,
    input  logic [MAX_BDIMBITS-1:0]          bstride,
    input  logic [$clog2(BEATS_PER_BLK)-1:0] beat,
    output logic [ADDR_WIDTH-1:0]            addr
);

    localparam int BB = $clog2(BEATS_PER_BLK);

    logic [ADDR_WIDTH-1:0] base_d;
    logic [ADDR_WIDTH-1:0] base_q;

    assign base_d = (ADDR_WIDTH'(y) * ADDR_WIDTH'(bstride)
                   + ADDR_WIDTH'(x)) << BB;

    always_ff @(posedge clk) begin
        if (load) base_q <= base_d;
    end

    // SOP beat uses the fresh base; the register is not loaded yet.
    assign addr = load ? base_d : base_q + ADDR_WIDTH'(beat);

endmodule

// File: rtl/lu_wrback.sv
// Block write-back: packetised beats to addressed memory writes.
// Optional protocol checking on o_err: define LU_WRBACK_ERRCHK_EN.
module lu_wrback
    import lu_new::*;
#(
    parameter int BEATS_PER_BLK = LU_BEATS_PER_BLK,
    parameter int ADDR_WIDTH    = LU_ADDR_WIDTH
) (
    input logic       clk,
    input logic       reset_n,
    lu_wrback_if.slave bus
);

    localparam int BB = $clog2(BEATS_PER_BLK);
    localparam logic [BB-1:0] LAST = BB'(BEATS_PER_BLK - 1);

    t_wrback_state state_q, state_d;
    logic [BB-1:0] cnt_q, cnt_d, beat;
    logic [MAX_BDIMBITS-1:0] x_q, y_q;
    logic                  mem_valid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q, addr;
    logic [NET_DWIDTH-1:0] mem_data_q;
    logic slot_free, accepting, xfer;
    logic in_idle, in_stream;
    logic sop_load, wr_en, last_beat;

    assign in_idle   = (state_q == S_IDLE);
    assign in_stream = (state_q == S_STREAM);
    assign slot_free = !mem_valid_q || bus.i_mem_ready;
    assign accepting = reset_n && slot_free
                     && (in_idle || in_stream);
    assign xfer      = bus.i_wrreq_valid && accepting;
    assign sop_load  = xfer && in_idle && bus.i_wrreq_sop;
    assign wr_en     = sop_load || (xfer && in_stream);
    assign beat      = in_stream ? cnt_q : '0;
    assign last_beat = (beat == LAST);

    lu_wrback_addrgen #(
        .BEATS_PER_BLK(BEATS_PER_BLK),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addrgen (
        .clk    (clk),
        .load   (sop_load),
        .x      (bus.i_wrreq_x),
        .y      (bus.i_wrreq_y),
        .bstride(bus.i_bstride),
        .beat   (beat),
        .addr   (addr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (sop_load) begin
                    cnt_d   = BB'(1);
                    state_d = bus.i_wrreq_eop ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (!last_beat) cnt_d = cnt_q + BB'(1);
                    if (bus.i_wrreq_eop) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (slot_free) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.i_blkdone_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (wr_en) mem_valid_q <= 1'b1;
            else if (bus.i_mem_ready) mem_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_addr_q <= addr;
            mem_data_q <= bus.i_wrreq_data;
        end
        if (sop_load) begin
            x_q <= bus.i_wrreq_x;
            y_q <= bus.i_wrreq_y;
        end
    end

    assign bus.o_wrreq_ready   = accepting;
    assign bus.o_mem_valid     = mem_valid_q;
    assign bus.o_mem_addr      = mem_addr_q;
    assign bus.o_mem_data      = mem_data_q;
    assign bus.o_blkdone_valid = (state_q == S_DONE);
    assign bus.o_blkdone_x     = x_q;
    assign bus.o_blkdone_y     = y_q;

`ifdef LU_WRBACK_ERRCHK_EN
    logic err_q, full_q, err_set;

    // full_q: the final beat slot has already been written this packet
    assign err_set = (xfer && in_idle && !bus.i_wrreq_sop)
                   || (xfer && in_stream && bus.i_wrreq_sop)
                   || (wr_en && bus.i_wrreq_eop && !last_beat)
                   || (xfer && in_stream && full_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (sop_load) full_q <= 1'b0;
            else if (wr_en && last_beat) full_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_lu_wrback.sv
// Scoreboard bench for lu_wrback: directed packets, decoupled monitor.
module tb_lu_wrback;
    import lu_new::*;

    localparam int AW = 24;
`ifdef LU_WRBACK_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [NET_DWIDTH-1:0] data;
    } mem_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    lu_wrback_if #(.ADDR_WIDTH(AW)) bus();

    lu_wrback #(
        .BEATS_PER_BLK(16),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    mem_t mem_q[$];
    logic [2*MAX_BDIMBITS-1:0] done_q[$];
    mem_t em;
    logic [2*MAX_BDIMBITS-1:0] ed;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_mem_cyc = -1;
    int last_done_cyc = -1;
    int gaps = 0;
    bit gap_chk = 1'b0;
    int mem_mode = 0;
    int bd_wait = 0;
    int c1, c2;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (mem_mode == 1) bus.i_mem_ready = ~bus.i_mem_ready;
        else bus.i_mem_ready = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (bus.o_blkdone_valid && bd_wait > 0) begin
            bus.i_blkdone_ready = 1'b0;
            bd_wait--;
        end else begin
            bus.i_blkdone_ready = 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.o_mem_valid && bus.i_mem_ready) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected got addr=%0d data=%h",
                             bus.o_mem_addr, bus.o_mem_data);
                end else begin
                    em = mem_q.pop_front();
                    if (bus.o_mem_addr !== em.addr
                        || bus.o_mem_data !== em.data) begin
                        errors++;
                        $display("FAIL mem_beat got %0d/%h want %0d/%h",
                                 bus.o_mem_addr, bus.o_mem_data,
                                 em.addr, em.data);
                    end
                end
                if (gap_chk && last_mem_cyc >= 0
                    && cyc != last_mem_cyc + 1) gaps++;
                last_mem_cyc = cyc;
            end
            if (bus.o_blkdone_valid && bus.i_blkdone_ready) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got x=%0d y=%0d",
                             bus.o_blkdone_x, bus.o_blkdone_y);
                end else begin
                    ed = done_q.pop_front();
                    if ({bus.o_blkdone_x, bus.o_blkdone_y} !== ed) begin
                        errors++;
                        $display("FAIL done_xy got %0d,%0d want %0d,%0d",
                                 bus.o_blkdone_x, bus.o_blkdone_y,
                                 ed[15:8], ed[7:0]);
                    end
                end
                last_done_cyc = cyc;
            end
            if (bus.o_mem_valid && !bus.i_mem_ready) begin
                checks++;
                if (bus.o_wrreq_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_when_full got %b want 0",
                             bus.o_wrreq_ready);
                end
            end
            if (bus.o_blkdone_valid) begin
                checks++;
                if (bus.o_wrreq_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_done got %b want 0",
                             bus.o_wrreq_ready);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d,
                             input logic [7:0] x, input logic [7:0] y,
                             input logic sop, input logic eop,
                             output int acc_cyc);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        acc_cyc = -1;
        bus.i_wrreq_data  = d;
        bus.i_wrreq_x     = x;
        bus.i_wrreq_y     = y;
        bus.i_wrreq_sop   = sop;
        bus.i_wrreq_eop   = eop;
        bus.i_wrreq_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.o_wrreq_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            n++;
        end
        #1;
        bus.i_wrreq_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout got no ready want ready");
        end
    endtask

    task automatic send_packet(input logic [7:0] x, input logic [7:0] y,
                               input int base, input int nbeats,
                               output int sop_cyc);
        logic [31:0] d;
        int c;
        int off;
        sop_cyc = -1;
        for (int i = 0; i < nbeats; i++) begin
            d = {8'hA5, x, y, 8'(i)};
            off = (i > 15) ? 15 : i;
            mem_q.push_back({AW'(base + off), d});
            send_beat(d, x, y, i == 0, i == nbeats - 1, c);
            if (i == 0) sop_cyc = c;
        end
        done_q.push_back({x, y});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((mem_q.size() != 0 || done_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name,
                     mem_q.size() + done_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        #1;
        chk({name, "_mem_valid"}, 64'(bus.o_mem_valid), 0);
        chk({name, "_done_valid"}, 64'(bus.o_blkdone_valid), 0);
        chk({name, "_wrreq_ready"}, 64'(bus.o_wrreq_ready), 0);
        chk({name, "_err"}, 64'(bus.o_err), 0);
        mem_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [31:0] d;
        bus.i_bstride       = 8'd4;
        bus.i_wrreq_valid   = 1'b0;
        bus.i_wrreq_data    = '0;
        bus.i_wrreq_x       = '0;
        bus.i_wrreq_y       = '0;
        bus.i_wrreq_sop     = 1'b0;
        bus.i_wrreq_eop     = 1'b0;
        bus.i_mem_ready     = 1'b1;
        bus.i_blkdone_ready = 1'b1;
        #2;
        do_reset("rst0");

        // 16 beats x=2 y=3 stride 4 -> 224..239, no gaps
        last_mem_cyc = -1;
        gap_chk = 1'b1;
        send_packet(8'd2, 8'd3, 224, 16, c1);
        wait_drain("t1");
        gap_chk = 1'b0;
        chk("t1_gaps", 64'(gaps), 0);
        chk("t1_done_lat", 64'(last_done_cyc), 64'(last_mem_cyc + 1));
        chk("t1_err", 64'(bus.o_err), 0);

        mem_mode = 1;
        send_packet(8'd2, 8'd3, 224, 16, c1);
        wait_drain("t2");
        mem_mode = 0;

        // done held 5 cycles; overlong second packet saturates at 95
        bd_wait = 5;
        send_packet(8'd0, 8'd0, 0, 16, c1);
        send_packet(8'd1, 8'd1, 80, 18, c2);
        chk("t3_sop_after_done", 64'(c2), 64'(last_done_cyc + 1));
        wait_drain("t3");
        chk("t3_err", 64'(bus.o_err), 64'(ERR_EXP));

        do_reset("rst4");
        send_beat(32'hDEAD_BEEF, 8'd7, 8'd7, 1'b0, 1'b0, c);
        send_packet(8'd1, 8'd0, 16, 16, c1);
        wait_drain("t4");
        chk("t4_err", 64'(bus.o_err), 64'(ERR_EXP));

        do_reset("rst5");
        send_packet(8'd0, 8'd1, 64, 10, c1);
        wait_drain("t5");
        chk("t5_err", 64'(bus.o_err), 64'(ERR_EXP));

        // reset right after beat 7 is accepted
        for (int i = 0; i < 7; i++) begin
            d = {8'h5A, 8'd3, 8'd2, 8'(i)};
            mem_q.push_back({AW'(176 + i), d});
            send_beat(d, 8'd3, 8'd2, i == 0, 1'b0, c);
        end
        do_reset("rst6");
        send_packet(8'd3, 8'd2, 176, 16, c1);
        wait_drain("t6");
        chk("t6_err", 64'(bus.o_err), 0);
        chk("t6_mem_valid", 64'(bus.o_mem_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
